// File: rtl/led_hb_pkg.sv
// led_hb_pkg: shared types and sizing helpers for the LED heartbeat block.
package led_hb_pkg;
  typedef enum logic [1:0] {
    MODE_OFF,
    MODE_ON,
    MODE_BLINK,
    MODE_BREATHE
  } mode_e;
  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;
  localparam int DEF_TICK_DIV     = 62500;
  localparam int DEF_BLINK_MS     = 500;
  localparam int DEF_BREATHE_STEP = 4;
  localparam int DEF_PWM_BITS     = 8;
  localparam int DEF_FLASH_MS     = 50;
  // Width of a counter holding values 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/led_hb_tick_gen.sv
// led_hb_tick_gen: prescaler producing a one-cycle pulse every TICK_DIV clocks.
module led_hb_tick_gen
  import led_hb_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);
  localparam int W = cnt_w(TICK_DIV);
  logic [W-1:0] r_cnt;
  assign tick_o = r_cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= tick_o ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/led_heartbeat.sv
// led_heartbeat: mode-selectable LED driver (off/on/blink/breathe) with a retriggerable event flash.
module led_heartbeat
  import led_hb_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int BLINK_MS     = DEF_BLINK_MS,
  parameter int BREATHE_STEP = DEF_BREATHE_STEP,
  parameter int PWM_BITS     = DEF_PWM_BITS,
  parameter int FLASH_MS     = DEF_FLASH_MS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode_i,
  input  logic                event_i,
  output logic                led_o,
  output logic                tick_o,
  output logic [PWM_BITS-1:0] duty_o
);
  localparam int MS_MAX = (BLINK_MS > BREATHE_STEP) ? BLINK_MS : BREATHE_STEP;
  localparam int MSW    = cnt_w(MS_MAX);
  localparam int FW     = cnt_w(FLASH_MS + 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  mode_e               w_mode;
  mode_e               r_mode_q;
  logic [MSW-1:0]      r_ms, w_ms_nxt;
  logic                r_blink, w_blink_nxt;
  dir_e                r_dir, w_dir_nxt;
  logic [PWM_BITS-1:0] r_duty, w_duty_nxt;
  logic [PWM_BITS-1:0] r_pwm;
  logic [FW-1:0]       r_flash, w_flash_nxt;
  logic                w_tick, w_chg, w_base, w_blink_end, w_step;
  led_hb_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick_o(w_tick)
  );
  assign tick_o      = w_tick;
  assign duty_o      = r_duty;
  assign w_mode      = mode_e'(mode_i);
  assign w_chg       = w_mode != r_mode_q;
  assign w_blink_end = r_ms == MSW'(BLINK_MS - 1);
  assign w_step      = r_ms == MSW'(BREATHE_STEP - 1);
  always_comb begin
    w_ms_nxt    = r_ms;
    w_blink_nxt = r_blink;
    w_dir_nxt   = r_dir;
    w_duty_nxt  = r_duty;
    if (w_chg) begin
      w_ms_nxt    = '0;
      w_blink_nxt = 1'b1;
      w_dir_nxt   = DIR_UP;
      w_duty_nxt  = '0;
    end else if (w_tick && w_mode == MODE_BLINK) begin
      w_ms_nxt    = w_blink_end ? '0 : r_ms + 1'b1;
      w_blink_nxt = w_blink_end ? ~r_blink : r_blink;
    end else if (w_tick && w_mode == MODE_BREATHE) begin
      w_ms_nxt = w_step ? '0 : r_ms + 1'b1;
      // Reversal happens on the step itself so duty never leaves 0..max.
      if (w_step && r_dir == DIR_UP) begin
        w_dir_nxt  = (r_duty == DUTY_MAX) ? DIR_DOWN : DIR_UP;
        w_duty_nxt = (r_duty == DUTY_MAX) ? DUTY_MAX - 1'b1 : r_duty + 1'b1;
      end else if (w_step) begin
        w_dir_nxt  = (r_duty == '0) ? DIR_UP : DIR_DOWN;
        w_duty_nxt = (r_duty == '0) ? PWM_BITS'(1) : r_duty - 1'b1;
      end
    end
    w_flash_nxt = event_i ? FW'(FLASH_MS) :
                  (w_tick && r_flash != '0) ? r_flash - 1'b1 : r_flash;
    // On a mode change the base uses the freshly cleared blink/duty values.
    w_base = (w_mode == MODE_OFF)   ? 1'b0 :
             (w_mode == MODE_ON)    ? 1'b1 :
             (w_mode == MODE_BLINK) ? (w_chg | r_blink) :
                                      (!w_chg && r_pwm < r_duty);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q <= MODE_OFF;
      r_ms     <= '0;
      r_blink  <= 1'b1;
      r_dir    <= DIR_UP;
      r_duty   <= '0;
      r_pwm    <= '0;
      r_flash  <= '0;
      led_o    <= 1'b0;
    end else begin
      r_mode_q <= w_mode;
      r_ms     <= w_ms_nxt;
      r_blink  <= w_blink_nxt;
      r_dir    <= w_dir_nxt;
      r_duty   <= w_duty_nxt;
      r_pwm    <= r_pwm + 1'b1;
      r_flash  <= w_flash_nxt;
      led_o    <= (r_flash != '0) ? ~w_base : w_base;
    end
  end
endmodule

// File: doc/led_heartbeat.md
Name: led_heartbeat

Overview:
- Consumer of the divided PCS TX clock (PCSCLKDIV CDIVX output), running entirely in that domain.
- Turns the recovered clock into a user-visible LED indication: off, on, blink or PWM "breathe", plus a retriggerable event flash.
- Replaces the free-running count-bit LED with a controlled, mode-selectable indicator.
- Its single output drives the board LED pad directly.

Parameters:
- TICK_DIV, 62500, clk cycles per millisecond tick (62.5 MHz divided clock); must be >= 2.
- BLINK_MS, 500, ticks per blink half-period; must be >= 1.
- BREATHE_STEP, 4, ticks between duty increments in BREATHE mode; must be >= 1.
- PWM_BITS, 8, width of the duty and PWM counters.
- FLASH_MS, 50, ticks the LED stays inverted after an event; must be >= 1.

Ports:
- clk  input  1  divided PCS TX clock
- rst_n  input  1  asynchronous assert, active-low reset
- mode_i  input  2  0=OFF, 1=ON, 2=BLINK, 3=BREATHE; sampled every cycle
- event_i  input  1  single-cycle pulse; requests a flash
- led_o  output  1  LED drive, registered, active-high
- tick_o  output  1  one-cycle pulse per millisecond tick
- duty_o  output  PWM_BITS  current breathe duty, registered

Behaviour:
- Reset (rst_n low, asynchronous):
  - led_o=0, tick_o=0, duty_o=0.
  - Tick counter=0, ms counter=0, blink_state=1, breathe direction=UP, flash counter=0, PWM counter=0.
  - Stored previous mode=OFF.
  - Deassertion is used as-is; reset synchronisation is external.
- Tick generator:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick_o=1 for the one cycle in which tick_cnt==TICK_DIV-1.
  - First tick after reset is at cycle TICK_DIV-1.
- Mode change:
  - mode_q registers mode_i.
  - When mode_i != mode_q: ms counter=0, blink_state=1, duty=0, direction=UP.
  - The tick generator and flash counter are not disturbed.
  - A pending tick in the change cycle is ignored by the ms/breathe logic.
- OFF: base=0. ON: base=1.
- BLINK:
  - base=blink_state.
  - On each tick, ms_cnt increments. At ms_cnt==BLINK_MS-1 with a tick, ms_cnt wraps to 0 and blink_state toggles.
  - Full period is 2*BLINK_MS ticks; the LED is on for the first half after entry.
- BREATHE:
  - On each tick, ms_cnt increments. At ms_cnt==BREATHE_STEP-1 with a tick, ms_cnt wraps and duty steps by 1 in the current direction.
  - At duty==2^PWM_BITS-1 going UP, direction flips and the step takes duty to max-1.
  - At duty==0 going DOWN, direction flips and the step takes duty to 1. No overflow or underflow ever occurs.
  - pwm_cnt is free-running per clk, PWM_BITS wide, wrapping at max.
  - base=(pwm_cnt < duty). Duty 0 gives always off; max gives on for all but one slot.
- duty_o:
  - Reflects the duty register in all modes.
  - Held at 0 outside BREATHE because a mode change clears it and only BREATHE steps it.
- Flash:
  - event_i loads flash_cnt=FLASH_MS. While flash_cnt != 0 the LED shows ~base.
  - flash_cnt decrements on each tick.
  - An event in the same cycle as a tick reloads to FLASH_MS; reload wins.
  - A retrigger during a flash restarts the full duration.
- Output: led_o <= flash_active ? ~base : base. Latency is 1 clk from the registered state/inputs to led_o.
- Reset mid-operation: all state returns to reset values immediately; there is no partial-state retention.

Decomposition:
- Package led_hb_pkg holds:
  - mode enum (MODE_OFF, MODE_ON, MODE_BLINK, MODE_BREATHE), 2 bits;
  - direction enum (DIR_UP, DIR_DOWN);
  - the localparam for the counter width derived from $clog2 of the parameters.
- Sub-module led_hb_tick_gen (param TICK_DIV; ports clk, rst_n, tick_o) isolates the prescaler and is reusable by other slow-rate blocks on the divided clock.

Test Plan (params TICK_DIV=4, BLINK_MS=3, BREATHE_STEP=1, PWM_BITS=3, FLASH_MS=2):
- Reset then idle with mode=OFF -> tick_o pulses at cycles 3, 7, 11…; led_o=0 and duty_o=0 throughout.
- mode=BLINK from reset -> led_o=1 for 3 ticks (12 clks), then 0 for 3 ticks, repeating; verify the toggle lands exactly on the tick cycle plus 1.
- mode=BREATHE -> duty_o sequence per tick is 0,1,…,7,6,…,0,1; duty=3 gives led_o high 3 of every 8 clks.
- mode=ON, event_i pulse -> led_o=0 for 2 ticks, then 1. Second event mid-flash -> flash extended to 2 ticks from the retrigger. Event coincident with a tick -> flash_cnt reloads to 2.
- Switch BREATHE→BLINK while duty=5 -> duty_o=0 and led_o=1 next cycle; blink half-period restarts from 0.
- Assert rst_n low mid-BLINK with a flash active -> led_o, tick_o and duty_o go to 0 asynchronously, before the next clk edge.
